spi_slave: RTL and testbench



---
 rtl/spi_slave.sv | 168 ++++++++++++++++
 tb/tb_spi_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// spi_slave: mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave. The SPI pins are
// oversampled in the clk domain. Bytes shifted in from the master appear on
// rx_data with a one-clk rx_valid pulse. Bytes to send come from a one-deep
// holding register that is written with tx_load while tx_ready is high.
//
// Ports:
//   clk, reset            system clock, async active-high reset
//   sclk, cs_n, mosi      SPI inputs from the master (asynchronous to clk)
//   miso                  SPI data to the master (registered)
//   tx_data, tx_load      holding register write; ignored unless tx_ready=1
//   tx_ready              holding register is empty
//   rx_data, rx_valid     last complete received word, one-clk update pulse
//   tx_underrun           one-clk pulse: a word started with no data held
//   frame_error           one-clk pulse: cs_n rose in the middle of a word
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_error
);

    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] ACTIVE    = 2'd2;

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam int SW = $clog2(SYNC_STAGES + 2);

    // Input synchronizers plus history flops for edge detection
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [SW-1:0]         settle_cnt;
    logic [DATA_WIDTH-2:0] rx_shift;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_full;
    logic                  word_load;

    assign rx_next = {rx_shift, mosi_s};
    assign tx_ready = ~hold_full;

    // A word load happens at frame start and at every word-boundary falling
    // edge; a cs_n rise in the same cycle wins over the sclk edge.
    assign word_load = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && sclk_fall &&
                        (bit_cnt == '0));

    // Holding register. A load is only taken while empty and a consume only
    // matters while full, so the two never collide; a same-cycle load and
    // consume on an empty register underruns and then holds the new byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_load && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (word_load && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= WAIT_IDLE;
            bit_cnt     <= '0;
            settle_cnt  <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;
            miso        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;
            miso        <= (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;

            if (word_load) begin
                tx_shift    <= hold_full ? hold_data : '1;
                tx_underrun <= ~hold_full;
            end

            case (state)
                WAIT_IDLE: begin
                    // The synchronizer resets to cs_n=1, so a reset taken
                    // mid-frame would look idle until the real pin level has
                    // flushed through. Wait for that before trusting cs_s.
                    bit_cnt <= '0;
                    if (settle_cnt != SW'(SYNC_STAGES + 1))
                        settle_cnt <= settle_cnt + 1'b1;
                    else if (cs_s)
                        state <= IDLE;
                end
                IDLE: begin
                    bit_cnt <= '0;
                    if (cs_fall)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        if (bit_cnt != '0)
                            frame_error <= 1'b1;
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[DATA_WIDTH-2:0];
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: acts as a mode-0 SPI master, keeps a
// scoreboard of bytes sent on mosi and compares them against rx_valid
// pulses, and compares bytes sampled on miso against expected values.
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic [DW-1:0] tx_data = '0;
    logic          tx_load = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx_underrun;
    logic          frame_error;

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            n_rxv = 0, n_und = 0, n_ferr = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: scoreboard pop on rx_valid, pulse counters
    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (tx_underrun) n_und++;
        if (frame_error) n_ferr++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [DW-1:0] v);
        tx_data = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    // Shift bits hi..lo; with last set, cs_n rises together with the final
    // sclk fall so no trailing word-boundary load happens.
    task automatic bits(input logic [DW-1:0] tx, input int hi, input int lo,
                        input bit last, output logic [DW-1:0] rx);
        rx = '0;
        for (int i = hi; i >= lo; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            sclk = 1'b1;
            rx[i] = miso;
            wait_clk(HALF);
            sclk = 1'b0;
            if (last && i == lo) cs_n = 1'b1;
        end
    endtask

    task automatic word(input logic [DW-1:0] tx, input bit last, output logic [DW-1:0] rx);
        exp_q.push_back(tx);
        bits(tx, DW-1, 0, last, rx);
    endtask

    typedef struct {
        bit            do_load;
        logic [DW-1:0] load_val;
        logic [DW-1:0] mosi_b;
        logic [DW-1:0] exp_miso;
        int            exp_und;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [DW-1:0] rx, rx2;
        int r0, u0, f0;

        tbl[0] = '{1'b1, 8'h3C, 8'hA5, 8'h3C, 0};
        tbl[1] = '{1'b0, 8'h00, 8'h0F, 8'hFF, 1};
        tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
        tbl[3] = '{1'b1, 8'h81, 8'h00, 8'h81, 0};

        // Reset state
        wait_clk(3);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_underrun", 32'(tx_underrun), 0);
        chk("rst_frame_error", 32'(frame_error), 0);
        reset = 1'b0;
        wait_clk(2 * HALF);

        // Single-word frames from the table
        foreach (tbl[k]) begin
            r0 = n_rxv; u0 = n_und; f0 = n_ferr;
            if (tbl[k].do_load) begin
                load(tbl[k].load_val);
                chk("tx_ready_full", 32'(tx_ready), 0);
            end
            cs_low();
            chk("tx_ready_after_cs", 32'(tx_ready), 1);
            word(tbl[k].mosi_b, 1'b1, rx);
            wait_clk(2 * HALF);
            chk("miso_byte", 32'(rx), 32'(tbl[k].exp_miso));
            chk("rx_valid_count", 32'(n_rxv - r0), 1);
            chk("underrun_count", 32'(n_und - u0), 32'(tbl[k].exp_und));
            chk("frame_error_count", 32'(n_ferr - f0), 0);
            chk("rx_data_hold", 32'(rx_data), 32'(tbl[k].mosi_b));
            chk("miso_idle", 32'(miso), 0);
        end

        // Two words under one cs_n, holding reloaded between them
        r0 = n_rxv; u0 = n_und;
        load(8'h56);
        cs_low();
        load(8'h78);
        word(8'h12, 1'b0, rx);
        word(8'h34, 1'b1, rx2);
        wait_clk(2 * HALF);
        chk("b2b_miso0", 32'(rx), 32'h56);
        chk("b2b_miso1", 32'(rx2), 32'h78);
        chk("b2b_rx_valid_count", 32'(n_rxv - r0), 2);
        chk("b2b_underrun_count", 32'(n_und - u0), 0);

        // cs_n rises after 5 bits
        r0 = n_rxv; f0 = n_ferr;
        cs_low();
        bits(8'hE7, 7, 3, 1'b0, rx);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(2 * HALF);
        chk("ferr_count", 32'(n_ferr - f0), 1);
        chk("ferr_no_rx_valid", 32'(n_rxv - r0), 0);
        chk("ferr_rx_data_kept", 32'(rx_data), 32'h34);

        // Next frame fine; a second load while full is ignored
        r0 = n_rxv; f0 = n_ferr;
        load(8'h42);
        load(8'h24);
        chk("ignored_load_ready", 32'(tx_ready), 0);
        cs_low();
        word(8'h99, 1'b1, rx);
        wait_clk(2 * HALF);
        chk("after_ferr_miso", 32'(rx), 32'h42);
        chk("after_ferr_rx_valid", 32'(n_rxv - r0), 1);
        chk("after_ferr_no_ferr", 32'(n_ferr - f0), 0);

        // Reset at bit 3 with cs_n low, finish that frame, then a new one
        r0 = n_rxv; f0 = n_ferr;
        load(8'h11);
        cs_low();
        bits(8'hAA, 7, 5, 1'b0, rx);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        bits(8'hAA, 4, 0, 1'b1, rx);
        wait_clk(2 * HALF);
        chk("rstmid_no_rx_valid", 32'(n_rxv - r0), 0);
        chk("rstmid_no_ferr", 32'(n_ferr - f0), 0);
        chk("rstmid_rx_data", 32'(rx_data), 0);
        chk("rstmid_tx_ready", 32'(tx_ready), 1);
        load(8'h5A);
        cs_low();
        word(8'hC3, 1'b1, rx);
        wait_clk(2 * HALF);
        chk("rstmid_next_miso", 32'(rx), 32'h5A);
        chk("rstmid_next_rx_valid", 32'(n_rxv - r0), 1);
        chk("rstmid_next_rx_data", 32'(rx_data), 32'hC3);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
